// File: rtl/switch_event_array.sv
// switch_event_array: debounced switch/sensor channels with press, long-press, counts, periods and readout
module switch_event_array #(
    parameter int NCH         = 4,
    parameter int DEB_CYCLES  = 32,
    parameter int LONG_CYCLES = 6400,
    parameter int CNT_W       = 16,
    parameter int PERIOD_W    = 16,
    parameter int TIME_W      = 32,
    localparam int SEL_W      = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NCH-1:0]      nIn,
    input  logic [NCH-1:0]      clear,
    input  logic                run,
    input  logic [SEL_W-1:0]    sel,
    output logic [NCH-1:0]      press,
    output logic [NCH-1:0]      long_press,
    output logic [NCH-1:0]      level,
    output logic [NCH-1:0]      stalled,
    output logic [TIME_W-1:0]   total_time,
    output logic [CNT_W-1:0]    rd_count,
    output logic [PERIOD_W-1:0] rd_period,
    output logic                rd_valid
);
    localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_V = HW'(LONG_CYCLES);
    localparam logic [PERIOD_W-1:0] PMAX = '1;

    logic [CNT_W-1:0]    count_a  [NCH];
    logic [PERIOD_W-1:0] period_a [NCH];
    logic [NCH-1:0]      valid_a;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic                s1, s2, deb, fall, seen, valid, p, lp;
        logic [DW-1:0]       dcnt;
        logic [HW-1:0]       hcnt;
        logic [CNT_W-1:0]    count;
        logic [PERIOD_W-1:0] timer, period;
        assign fall = deb & ~s2 & (dcnt == DEB_LAST);
        assign press[i] = p;
        assign long_press[i] = lp;
        assign level[i] = ~deb;
        assign stalled[i] = timer == PMAX;
        assign count_a[i] = count;
        assign period_a[i] = period;
        assign valid_a[i] = valid;
        // synchroniser, debounce filter, press and long-press pulse generation
        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                s1   <= 1'b1;
                s2   <= 1'b1;
                deb  <= 1'b1;
                dcnt <= '0;
                hcnt <= '0;
                p    <= 1'b0;
                lp   <= 1'b0;
            end else begin
                s1 <= nIn[i];
                s2 <= s1;
                if (s2 == deb)
                    dcnt <= '0;
                else if (dcnt == DEB_LAST) begin
                    deb  <= s2;
                    dcnt <= '0;
                end else
                    dcnt <= dcnt + 1'b1;
                p    <= fall;
                lp   <= ~deb & (hcnt == LONG_V - 1'b1);
                hcnt <= deb ? '0 : (hcnt == LONG_V ? hcnt : hcnt + 1'b1);
            end
        end
        // event counter and press-to-press period timer; clear wins over a coincident press
        always_ff @(posedge HCLK) begin
            if (HRESET || clear[i]) begin
                count  <= '0;
                timer  <= '0;
                period <= '0;
                valid  <= 1'b0;
                seen   <= 1'b0;
            end else if (fall) begin
                count <= count + 1'b1;
                seen  <= 1'b1;
                timer <= PERIOD_W'(1);
                if (seen) begin
                    period <= timer == PMAX ? '0 : timer;
                    valid  <= timer != PMAX;
                end
            end else begin
                if (timer != PMAX)
                    timer <= timer + 1'b1;
                if (timer >= PMAX - 1'b1) begin
                    period <= '0;
                    valid  <= 1'b0;
                end
            end
        end
    end

    // free-running run-gated time base and registered channel readout
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            total_time <= '0;
            rd_count   <= '0;
            rd_period  <= '0;
            rd_valid   <= 1'b0;
        end else begin
            total_time <= run ? total_time + 1'b1 : total_time;
            rd_count   <= int'(sel) < NCH ? count_a[sel] : '0;
            rd_period  <= int'(sel) < NCH ? period_a[sel] : '0;
            rd_valid   <= int'(sel) < NCH ? valid_a[sel] : 1'b0;
        end
    end
endmodule
